// File: rtl/cx_dma_req_arbiter_pkg.sv
// Shared types and sizing for the cx_dma request arbiter.
// Build option: CX_ARB_PERF_EN adds per-requester grant counters.
package cx_arb_types;
   localparam int NUM_REQ       = 2;
   localparam int DATA_W        = 64;
   localparam int ID_W          = 4;
   localparam int STRM_W        = 64;
   localparam int WR_FIFO_DEPTH = 4;
   localparam int IDX_W         = $clog2(NUM_REQ);
   localparam int CNT_W         = $clog2(WR_FIFO_DEPTH) + 1;

   typedef logic [IDX_W-1:0] arb_idx_t;

   typedef struct packed {
      logic                  write;
      logic [IDX_W+ID_W-1:0] id;
      logic [DATA_W-1:0]     data;
   } arb_req_t;

   function automatic arb_idx_t rr_next(arb_idx_t g);
      return (int'(g) == NUM_REQ - 1) ? '0 : g + arb_idx_t'(1);
   endfunction
endpackage

// File: rtl/cx_dma_req_arbiter_if.sv
// Request and write-stream bundle between the requesters and cx_dma_unit.
// master = arbiter view, slave = requester/downstream view.
interface cx_dma_req_arbiter_if;
   import cx_arb_types::*;

   logic [NUM_REQ-1:0]        s_req_valid;
   logic [NUM_REQ-1:0]        s_req_ready;
   logic [NUM_REQ-1:0]        s_req_write;
   logic [NUM_REQ*DATA_W-1:0] s_req_data;
   logic [NUM_REQ*ID_W-1:0]   s_req_id;
   logic                      m_req_valid;
   logic                      m_req_ready;
   logic                      m_req_write;
   logic [DATA_W-1:0]         m_req_data;
   logic [IDX_W+ID_W-1:0]     m_req_id;
   logic [NUM_REQ-1:0]        s_wstrm_valid;
   logic [NUM_REQ-1:0]        s_wstrm_ready;
   logic [NUM_REQ*STRM_W-1:0] s_wstrm_data;
   logic [NUM_REQ-1:0]        s_wstrm_last;
   logic                      m_wstrm_valid;
   logic                      m_wstrm_ready;
   logic [STRM_W-1:0]         m_wstrm_data;
   logic                      m_wstrm_last;

   modport master (
      input  s_req_valid, s_req_write, s_req_data, s_req_id,
      output s_req_ready,
      output m_req_valid, m_req_write, m_req_data, m_req_id,
      input  m_req_ready,
      input  s_wstrm_valid, s_wstrm_data, s_wstrm_last,
      output s_wstrm_ready,
      output m_wstrm_valid, m_wstrm_data, m_wstrm_last,
      input  m_wstrm_ready
   );

   modport slave (
      output s_req_valid, s_req_write, s_req_data, s_req_id,
      input  s_req_ready,
      input  m_req_valid, m_req_write, m_req_data, m_req_id,
      output m_req_ready,
      output s_wstrm_valid, s_wstrm_data, s_wstrm_last,
      input  s_wstrm_ready,
      input  m_wstrm_valid, m_wstrm_data, m_wstrm_last,
      output m_wstrm_ready
   );
endinterface

// File: rtl/cx_dma_req_arbiter_order_fifo.sv
// Small FIFO recording which requester owns each accepted write,
// so its data beats are forwarded in acceptance order.
module cx_arb_order_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 1,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         empty,
   output logic [AW:0]  count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rp];
   assign empty = (count == '0);
endmodule

// File: rtl/cx_dma_req_arbiter.sv
// Round-robin merge of CXU request packets onto one cx_dma_unit port,
// with write beats steered in write-acceptance order. Option: CX_ARB_PERF_EN.
module cx_dma_req_arbiter
   import cx_arb_types::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   cx_dma_req_arbiter_if.master bus
`ifdef CX_ARB_PERF_EN
   ,
   output logic [NUM_REQ*32-1:0] o_grant_cnt
`endif
);
   logic               load;
   logic               found;
   logic               wr_room;
   logic               push;
   logic               pop;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic [NUM_REQ-1:0] elig;
   arb_idx_t           gnt;
   arb_idx_t           ptr;
   arb_idx_t           head;
   arb_idx_t           scan;
   arb_req_t           req_q;
   logic               valid_q;

   // An in-flight write in the output register already owns a FIFO slot.
   assign wr_room = (int'(fifo_count) + int'(valid_q && req_q.write))
                    < WR_FIFO_DEPTH;
   assign load = !valid_q || bus.m_req_ready;

   always_comb begin
      for (int r = 0; r < NUM_REQ; r++) begin
         elig[r] = bus.s_req_valid[r] && (!bus.s_req_write[r] || wr_room);
      end
   end

   always_comb begin
      found = 1'b0;
      gnt   = ptr;
      scan  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = ((int'(ptr) + k) >= NUM_REQ)
              ? arb_idx_t'(int'(ptr) + k - NUM_REQ)
              : arb_idx_t'(int'(ptr) + k);
         if (!found && elig[scan]) begin
            found = 1'b1;
            gnt   = scan;
         end
      end
   end

   always_comb begin
      bus.s_req_ready = '0;
      if (load && found) bus.s_req_ready[gnt] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= 1'b0;
         req_q   <= '0;
         ptr     <= '0;
      end else if (load) begin
         valid_q <= found;
         if (found) begin
            req_q.write <= bus.s_req_write[gnt];
            req_q.id    <= {gnt, bus.s_req_id[int'(gnt)*ID_W +: ID_W]};
            req_q.data  <= bus.s_req_data[int'(gnt)*DATA_W +: DATA_W];
            ptr         <= rr_next(gnt);
         end
      end
   end

   assign bus.m_req_valid = valid_q;
   assign bus.m_req_write = req_q.write;
   assign bus.m_req_id    = req_q.id;
   assign bus.m_req_data  = req_q.data;

   assign push = valid_q && bus.m_req_ready && req_q.write;
   assign pop  = bus.m_wstrm_valid && bus.m_wstrm_ready && bus.m_wstrm_last;

   cx_arb_order_fifo #(
      .DEPTH (WR_FIFO_DEPTH),
      .W     (IDX_W)
   ) u_order (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (push),
      .wdata (req_q.id[ID_W +: IDX_W]),
      .pop   (pop),
      .rdata (head),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.m_wstrm_valid = !fifo_empty && bus.s_wstrm_valid[head];
   assign bus.m_wstrm_last  = !fifo_empty && bus.s_wstrm_last[head];
   assign bus.m_wstrm_data  = bus.s_wstrm_data[int'(head)*STRM_W +: STRM_W];

   always_comb begin
      bus.s_wstrm_ready = '0;
      if (!fifo_empty && bus.m_wstrm_ready) bus.s_wstrm_ready[head] = 1'b1;
   end

`ifdef CX_ARB_PERF_EN
   logic [31:0] gcnt [NUM_REQ];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < NUM_REQ; r++) gcnt[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (bus.s_req_valid[r] && bus.s_req_ready[r] && gcnt[r] != '1)
               gcnt[r] <= gcnt[r] + 32'd1;
         end
      end
   end

   always_comb begin
      o_grant_cnt = '0;
      for (int r = 0; r < NUM_REQ; r++) o_grant_cnt[r*32 +: 32] = gcnt[r];
   end
`endif
endmodule

// File: tb/tb_cx_dma_req_arbiter.sv
// Directed bench for cx_dma_req_arbiter (NUM_REQ=2, depth 4).
// Grant-counter checks run only when CX_ARB_PERF_EN is defined.
module tb_cx_dma_req_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   cx_dma_req_arbiter_if bus ();

`ifdef CX_ARB_PERF_EN
   logic [63:0] grant_cnt;
`endif

   cx_dma_req_arbiter dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .bus         (bus)
`ifdef CX_ARB_PERF_EN
      ,
      .o_grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.s_req_valid   = '0;
      bus.s_req_write   = '0;
      bus.s_req_data    = '0;
      bus.s_req_id      = '0;
      bus.m_req_ready   = 1'b0;
      bus.s_wstrm_valid = '0;
      bus.s_wstrm_data  = '0;
      bus.s_wstrm_last  = '0;
      bus.m_wstrm_ready = 1'b0;
   endtask

   initial begin
      clear_inputs();
      #1 rst_n = 1'b0;
      #1;
      check("rst_mvalid", bus.m_req_valid, 1'b0);
      check("rst_sready", bus.s_req_ready, 2'b00);
      check("rst_wvalid", bus.m_wstrm_valid, 1'b0);
      check("rst_wready", bus.s_wstrm_ready, 2'b00);
      check("rst_id", bus.m_req_id, 5'h00);
      #10 rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle", {bus.s_req_ready, bus.m_req_valid}, 3'b000);
      end

      // Both requesters reading: strict alternation starting at r0.
      bus.m_req_ready       = 1'b1;
      bus.s_req_data[63:0]  = 64'hA0A0;
      bus.s_req_data[127:64] = 64'hB1B1;
      bus.s_req_id          = {4'h5, 4'h3};
      bus.s_req_valid       = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("rr_ready", bus.s_req_ready, (k % 2) ? 2'b10 : 2'b01);
         tick();
         check("rr_valid", bus.m_req_valid, 1'b1);
         check("rr_id", bus.m_req_id, (k % 2) ? 5'h15 : 5'h03);
         check("rr_data", bus.m_req_data, (k % 2) ? 64'hB1B1 : 64'hA0A0);
      end
      bus.s_req_valid = 2'b00;
      #1;
      tick();
      check("rr_drain", bus.m_req_valid, 1'b0);

      // Downstream stall: output held, no further accepts.
      bus.m_req_ready      = 1'b0;
      bus.s_req_data[63:0] = 64'hC0C0;
      bus.s_req_valid      = 2'b01;
      #1;
      check("stall_ready0", bus.s_req_ready, 2'b01);
      tick();
      check("stall_load", bus.m_req_data, 64'hC0C0);
      bus.s_req_data[63:0] = 64'hDEAD;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_ready", bus.s_req_ready, 2'b00);
         check("stall_valid", bus.m_req_valid, 1'b1);
         check("stall_data", bus.m_req_data, 64'hC0C0);
         tick();
      end
      bus.m_req_ready = 1'b1;
      bus.s_req_valid = 2'b00;
      #1;
      tick();
      check("stall_done", bus.m_req_valid, 1'b0);

      // Write ordering: r1 beats offered early must wait behind r0's burst.
      bus.m_wstrm_ready         = 1'b1;
      bus.s_wstrm_valid[1]      = 1'b1;
      bus.s_wstrm_data[127:64]  = 64'hB0;
      bus.s_wstrm_last[1]       = 1'b0;
      bus.s_req_id              = {4'h2, 4'h7};
      bus.s_req_write           = 2'b01;
      bus.s_req_valid           = 2'b01;
      #1;
      check("wr0_ready", bus.s_req_ready, 2'b01);
      check("wr_empty_v", bus.m_wstrm_valid, 1'b0);
      check("wr_empty_r", bus.s_wstrm_ready, 2'b00);
      tick();
      check("wr0_id", {bus.m_req_write, bus.m_req_id}, 6'h27);
      bus.s_req_write = 2'b10;
      bus.s_req_valid = 2'b10;
      #1;
      check("wr1_ready", bus.s_req_ready, 2'b10);
      check("wr_noearly", bus.m_wstrm_valid, 1'b0);
      tick();
      bus.s_req_valid = 2'b00;
      #1;
      check("wr1_id", {bus.m_req_write, bus.m_req_id}, 6'h32);
      check("wr_hold_r1", bus.m_wstrm_valid, 1'b0);
      check("wr_head_r0", bus.s_wstrm_ready, 2'b01);
      tick();
      for (int b = 0; b < 3; b++) begin
         bus.s_wstrm_valid[0]    = 1'b1;
         bus.s_wstrm_data[63:0]  = 64'hA0 + 64'(b);
         bus.s_wstrm_last[0]     = (b == 2);
         #1;
         check("r0_beat_v", bus.m_wstrm_valid, 1'b1);
         check("r0_beat_d", {bus.m_wstrm_last, bus.m_wstrm_data},
               {(b == 2), 64'hA0 + 64'(b)});
         check("r0_beat_r", bus.s_wstrm_ready, 2'b01);
         tick();
      end
      bus.s_wstrm_valid[0] = 1'b0;
      bus.s_wstrm_last[0]  = 1'b0;
      #1;
      check("r1_beat0", {bus.m_wstrm_valid, bus.m_wstrm_last,
            bus.m_wstrm_data}, {2'b10, 64'hB0});
      check("r1_ready", bus.s_wstrm_ready, 2'b10);
      tick();
      bus.s_wstrm_data[127:64] = 64'hB1;
      bus.s_wstrm_last[1]      = 1'b1;
      #1;
      check("r1_beat1", {bus.m_wstrm_valid, bus.m_wstrm_last,
            bus.m_wstrm_data}, {2'b11, 64'hB1});
      tick();
      bus.s_wstrm_valid = 2'b00;
      bus.s_wstrm_last  = 2'b00;
      #1;
      check("wr_drained", {bus.m_wstrm_valid, bus.s_wstrm_ready}, 3'b000);

      // Four writes fill the order FIFO; a read still gets through.
      bus.m_wstrm_ready = 1'b0;
      bus.s_req_write   = 2'b01;
      bus.s_req_valid   = 2'b01;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("fill_ready", bus.s_req_ready, 2'b01);
         tick();
      end
      #1;
      check("full_hold", bus.s_req_ready, 2'b00);
      bus.s_req_valid = 2'b11;
      #1;
      check("full_read", bus.s_req_ready, 2'b10);
      tick();
      check("full_rd_out", {bus.m_req_valid, bus.m_req_write, bus.m_req_id},
            7'h52);
      check("full_rd_again", bus.s_req_ready, 2'b10);

      // Asynchronous reset mid-transfer discards held and queued state.
      bus.s_req_valid      = 2'b00;
      bus.s_wstrm_valid[0] = 1'b1;
      bus.s_wstrm_last[0]  = 1'b1;
      bus.m_wstrm_ready    = 1'b1;
      #1;
      check("pre_rst_wr", bus.s_wstrm_ready, 2'b01);
      #1 rst_n = 1'b0;
      #1;
      check("arst_mvalid", bus.m_req_valid, 1'b0);
      check("arst_wstrm", {bus.m_wstrm_valid, bus.s_wstrm_ready}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      clear_inputs();

`ifdef CX_ARB_PERF_EN
      tick();
      bus.m_req_ready = 1'b1;
      bus.s_req_valid = 2'b01;
      for (int i = 0; i < 7; i++) tick();
      bus.s_req_valid = 2'b10;
      for (int i = 0; i < 3; i++) tick();
      bus.s_req_valid = 2'b00;
      #1;
      check("perf_cnt", grant_cnt, {32'd3, 32'd7});
      bus.s_req_write   = 2'b01;
      bus.s_req_valid   = 2'b01;
      tick();
      bus.s_req_valid   = 2'b00;
      tick();
      bus.m_wstrm_ready    = 1'b1;
      bus.s_wstrm_valid[0] = 1'b1;
      #1;
      check("perf_burst", bus.s_wstrm_ready, 2'b01);
      tick();
      #1 rst_n = 1'b0;
      #1;
      check("perf_rst_cnt", grant_cnt, 64'h0);
      check("perf_rst_fifo", bus.s_wstrm_ready, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      clear_inputs();
`endif

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
